// File: rtl/key_schedule_ctrl.sv
// rtl/key_schedule_ctrl.sv - AES-128 key schedule controller; optional registered read port via KEY_SCHED_RDREG_EN

// One AES-128 key-expansion round: next round key from the previous one and {rcon, 24'h0}.
module KeyExpansion (
   input  logic [127:0] datain,
   input  logic [31:0]  cuurentkey,
   output logic [127:0] dataout
);

   // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // S-box as multiplicative inverse (x^254, so 0 maps to 0) followed by the affine transform
   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] sq;
      logic [7:0] inv;
      sq  = gf_mul(x, x);
      inv = 8'h01;
      for (int i = 1; i < 8; i++) begin
         inv = gf_mul(inv, sq);
         sq  = gf_mul(sq, sq);
      end
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                 ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   logic [31:0] w0, w1, w2, w3, rot, sub, n0, n1, n2, n3;

   assign w0  = datain[127:96];
   assign w1  = datain[95:64];
   assign w2  = datain[63:32];
   assign w3  = datain[31:0];
   assign rot = {w3[23:0], w3[31:24]};
   assign sub = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
   assign n0  = w0 ^ sub ^ cuurentkey;
   assign n1  = w1 ^ n0;
   assign n2  = w2 ^ n1;
   assign n3  = w3 ^ n2;
   assign dataout = {n0, n1, n2, n3};

endmodule

module key_schedule_ctrl (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [127:0] key_in,
   input  logic         key_valid,
   output logic         key_ready,
   input  logic         flush,
   output logic         busy,
   output logic         done,
   input  logic [3:0]   rk_addr,
   output logic [127:0] rk_data
);

   typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

   state_t       state;
   logic [3:0]   round;
   logic [7:0]   rcon;
   logic [127:0] rk [0:10];
   logic [127:0] prev_rk;
   logic [127:0] next_rk;
   logic [127:0] rd_mux;

   // Previous round key feeding the expansion round; zero outside rounds 1..10
   always_comb begin
      prev_rk = '0;
      for (int i = 0; i < 10; i++) begin
         if (round == 4'(i + 1)) prev_rk = rk[i];
      end
   end

   KeyExpansion u_key_expansion (
      .datain     (prev_rk),
      .cuurentkey ({rcon, 24'h0}),
      .dataout    (next_rk)
   );

   // Control FSM and round-key storage; flush outranks key accept and keeps stored keys
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         round     <= 4'd0;
         rcon      <= 8'h01;
         done      <= 1'b0;
         busy      <= 1'b0;
         key_ready <= 1'b1;
         for (int i = 0; i < 11; i++) rk[i] <= '0;
      end else if (flush) begin
         state     <= IDLE;
         round     <= 4'd0;
         done      <= 1'b0;
         busy      <= 1'b0;
         key_ready <= 1'b1;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (key_valid) begin
                  rk[0]     <= key_in;
                  round     <= 4'd1;
                  rcon      <= 8'h01;
                  done      <= 1'b0;
                  busy      <= 1'b1;
                  key_ready <= 1'b0;
                  state     <= EXPAND;
               end
            end
            EXPAND: begin
               for (int i = 1; i < 11; i++) begin
                  if (round == 4'(i)) rk[i] <= next_rk;
               end
               round <= round + 4'd1;
               rcon  <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
               if (round == 4'd10) begin
                  state     <= DONE;
                  done      <= 1'b1;
                  busy      <= 1'b0;
                  key_ready <= 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               busy      <= 1'b0;
               key_ready <= 1'b1;
            end
         endcase
      end
   end

   // Read mux: addresses 11..15 read as zero
   always_comb begin
      rd_mux = '0;
      for (int i = 0; i < 11; i++) begin
         if (rk_addr == 4'(i)) rd_mux = rk[i];
      end
   end

`ifdef KEY_SCHED_RDREG_EN
   // Registered read port: one cycle from rk_addr to rk_data
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rk_data <= '0;
      else        rk_data <= rd_mux;
   end
`else
   assign rk_data = rd_mux;
`endif

endmodule

// File: tb/tb_key_schedule_ctrl.sv
// tb/tb_key_schedule_ctrl.sv - self-checking bench for key_schedule_ctrl
module tb_key_schedule_ctrl;

   logic         clk;
   logic         rst_n;
   logic [127:0] key_in;
   logic         key_valid;
   logic         key_ready;
   logic         flush;
   logic         busy;
   logic         done;
   logic [3:0]   rk_addr;
   logic [127:0] rk_data;

   int n_checks = 0;
   int n_fail   = 0;
   logic chk_en = 1'b0;

   key_schedule_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .key_in    (key_in),
      .key_valid (key_valid),
      .key_ready (key_ready),
      .flush     (flush),
      .busy      (busy),
      .done      (done),
      .rk_addr   (rk_addr),
      .rk_data   (rk_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference AES-128 key expansion ----------------
   logic [7:0] sb [256];
   logic [7:0] rcl [10];

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [15:0] prod;
      prod = 16'h0;
      for (int i = 0; i < 8; i++) if (b[i]) prod = prod ^ (16'(a) << i);
      for (int i = 14; i >= 8; i--) if (prod[i]) prod = prod ^ (16'h011b << (i - 8));
      return prod[7:0];
   endfunction

   task automatic build_sbox();
      logic [7:0] inv, s, c;
      c = 8'h63;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         for (int i = 0; i < 8; i++)
            s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8] ^ inv[(i + 7) % 8] ^ c[i];
         sb[x] = s;
      end
      rcl = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
   endtask

   function automatic logic [127:0] round_key(input logic [127:0] key, input int r);
      logic [31:0] w [44];
      logic [31:0] t;
      for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i - 1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rcl[i / 4 - 1], 24'h0};
         end
         w[i] = w[i - 4] ^ t;
      end
      return {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
   endfunction

   // ---------------- behavioural model ----------------
   logic         m_exp, m_done;
   int           m_cnt;
   logic [127:0] m_key;
   logic [127:0] m_rk [11];
   logic [127:0] m_rd;
   logic [127:0] exp_rd;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_exp  <= 1'b0;
         m_done <= 1'b0;
         m_cnt  <= 0;
         m_rd   <= '0;
         m_key  <= '0;
         for (int i = 0; i < 11; i++) m_rk[i] <= '0;
      end else begin
         m_rd <= (rk_addr <= 4'd10) ? m_rk[rk_addr] : '0;
         if (flush) begin
            m_exp  <= 1'b0;
            m_done <= 1'b0;
         end else if (m_exp) begin
            m_rk[m_cnt + 1] <= round_key(m_key, m_cnt + 1);
            m_cnt <= m_cnt + 1;
            if (m_cnt + 1 == 10) begin
               m_exp  <= 1'b0;
               m_done <= 1'b1;
            end
         end else if (key_valid) begin
            m_key   <= key_in;
            m_rk[0] <= key_in;
            m_cnt   <= 0;
            m_exp   <= 1'b1;
            m_done  <= 1'b0;
         end
      end
   end

`ifdef KEY_SCHED_RDREG_EN
   always_comb exp_rd = m_rd;
`else
   always_comb exp_rd = (rk_addr <= 4'd10) ? m_rk[rk_addr] : '0;
`endif

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
      end
   endtask

   // Per-cycle comparison of every output against the model
   always @(negedge clk) begin
      if (chk_en) begin
         check("key_ready", 128'(key_ready), 128'(!m_exp));
         check("busy", 128'(busy), 128'(m_exp));
         check("done", 128'(done), 128'(m_done));
         check("rk_data", rk_data, exp_rd);
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic read_rk(input logic [3:0] a, output logic [127:0] d);
      rk_addr = a;
`ifdef KEY_SCHED_RDREG_EN
      tick();
`endif
      @(negedge clk);
      d = rk_data;
      #1;
   endtask

   // Accept key, optionally keep key_valid high with another key through EXPAND; returns cycles to done
   task automatic run_key(input logic [127:0] key, input logic hold, input logic [127:0] other, output int lat);
      key_in    = key;
      key_valid = 1'b1;
      tick();
      if (hold) key_in = other;
      else      key_valid = 1'b0;
      lat = 0;
      for (int c = 1; c <= 20; c++) begin
         @(posedge clk);
         #1;
         if (c >= 10) key_valid = 1'b0;
         rk_addr = 4'(c % 16);
         @(negedge clk);
         if (done) begin
            lat = c;
            break;
         end
      end
      #1;
   endtask

   localparam logic [127:0] KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] KEY_B = 128'hffeeddccbbaa99887766554433221100;
   localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;

   initial begin
      int lat;
      logic [127:0] d;
      rst_n = 1'b0; key_in = '0; key_valid = 1'b0; flush = 1'b0; rk_addr = 4'd0;
      build_sbox();
      // Model sanity against known values
      check("model_rk1", round_key(KEY_A, 1), 128'ha0fafe1788542cb123a339392a6c7605);
      check("model_rk10", round_key(KEY_A, 10), 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      tick();
      chk_en = 1'b1;
      tick();
      @(negedge clk);
      check("reset_key_ready", 128'(key_ready), 128'(1));
      check("reset_busy", 128'(busy), 128'(0));
      check("reset_done", 128'(done), 128'(0));
      check("reset_rk_data", rk_data, 128'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      tick();

      // Basic expansion
      run_key(KEY_A, 1'b0, '0, lat);
      check("latency_a", 128'(lat), 128'(10));
      read_rk(4'd1, d);  check("a_rk1", d, 128'ha0fafe1788542cb123a339392a6c7605);
      read_rk(4'd10, d); check("a_rk10", d, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      read_rk(4'd0, d);  check("a_rk0", d, KEY_A);

      // key_valid held with another key during EXPAND
      run_key(KEY_A, 1'b1, KEY_B, lat);
      check("latency_hold", 128'(lat), 128'(10));
      read_rk(4'd10, d); check("hold_rk10", d, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      read_rk(4'd11, d); check("addr11", d, 128'h0);
      read_rk(4'd15, d); check("addr15", d, 128'h0);

      // flush together with key_valid at round 5
      key_in = KEY_A; key_valid = 1'b1;
      tick();
      key_valid = 1'b0;
      repeat (4) tick();
      flush = 1'b1; key_valid = 1'b1; key_in = KEY_B;
      tick();
      flush = 1'b0; key_valid = 1'b0;
      @(negedge clk);
      check("flush_done", 128'(done), 128'(0));
      check("flush_busy", 128'(busy), 128'(0));
      check("flush_ready", 128'(key_ready), 128'(1));
      #1;
      read_rk(4'd0, d);  check("flush_rk0_kept", d, KEY_A);
      run_key(KEY_C, 1'b0, '0, lat);
      check("latency_c", 128'(lat), 128'(10));
      read_rk(4'd10, d); check("c_rk10", d, 128'h13111d7fe3944a17f307a78b4d2b30c5);

      // Restart from DONE with a second key
      run_key(KEY_A, 1'b0, '0, lat);
      run_key(KEY_C, 1'b0, '0, lat);
      check("latency_restart", 128'(lat), 128'(10));
      read_rk(4'd10, d); check("restart_rk10", d, 128'h13111d7fe3944a17f307a78b4d2b30c5);

      // Reset pulsed at round 3
      key_in = KEY_A; key_valid = 1'b1;
      tick();
      key_valid = 1'b0;
      repeat (2) tick();
      #2 rst_n = 1'b0;
      @(negedge clk);
      check("rst_busy", 128'(busy), 128'(0));
      check("rst_done", 128'(done), 128'(0));
      check("rst_ready", 128'(key_ready), 128'(1));
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int a = 0; a <= 10; a++) begin
         read_rk(4'(a), d);
         check("rst_rk_zero", d, 128'h0);
      end
      repeat (3) tick();
      check("rst_stays_idle", 128'(busy), 128'(0));

      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
